// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared types and classification helpers for the branch predictor update path
//
// Purpose : defines the update command carried from branch resolution to the
//           BTB/RAS, and the pure functions that classify a resolved branch.
// Contents: BTB_IDX_W, upd_cmd_t, classify(), cmd_has_work(), needs_redirect().

package bpu_pkg;

  // Width of a BTB entry index (32-entry BTB).
  localparam int BTB_IDX_W = 5;

  // One maintenance command for the predictor, as held in the update FIFO.
  typedef struct packed {
    logic [31:0]          pc;
    logic [BTB_IDX_W-1:0] index;
    logic                 pop_ras;
    logic                 push_ras;
    logic                 add_entry;
    logic                 delete_entry;
    logic                 pre_error;
    logic                 pre_right;
    logic                 target_error;
    logic                 right_orien;
    logic [31:0]          right_target;
  } upd_cmd_t;

  // Build the update command for one resolved record.
  function automatic upd_cmd_t classify(
    input logic [31:0]          pc,
    input logic                 is_branch,
    input logic                 is_call,
    input logic                 is_ret,
    input logic                 pred_hit,
    input logic [BTB_IDX_W-1:0] pred_index,
    input logic                 pred_taken,
    input logic [31:0]          pred_target,
    input logic                 act_taken,
    input logic [31:0]          act_target
  );
    upd_cmd_t c;
    logic     dir_err;
    logic     tgt_err;
    dir_err = pred_taken != act_taken;
    // A target is only wrong when both sides agree the branch was taken.
    tgt_err = pred_taken && act_taken && (pred_target != act_target);

    c.pc           = pc;
    c.index        = pred_index;
    c.add_entry    = !pred_hit && act_taken && is_branch;
    // A hit on a non-branch means the BTB entry aliases another pc.
    c.delete_entry = pred_hit && !is_branch;
    c.pre_error    = pred_hit && is_branch && dir_err;
    c.pre_right    = pred_hit && is_branch && !dir_err && !tgt_err;
    c.target_error = tgt_err;
    c.push_ras     = is_call && act_taken;
    c.pop_ras      = is_ret;
    c.right_orien  = act_taken;
    c.right_target = act_target;
    return c;
  endfunction

  // Commands with no structural op and no outcome class are not worth queueing.
  function automatic logic cmd_has_work(input upd_cmd_t c);
    return c.pop_ras || c.push_ras || c.add_entry || c.delete_entry ||
           c.pre_error || c.pre_right || c.target_error;
  endfunction

  // Fetch went down the wrong path: wrong direction, wrong target, or it
  // followed an aliased entry that predicted taken.
  function automatic logic needs_redirect(
    input upd_cmd_t c,
    input logic     pred_taken,
    input logic     act_taken
  );
    return (pred_taken != act_taken) || c.target_error ||
           (c.delete_entry && pred_taken);
  endfunction

endpackage

// File: rtl/bpu_upd_fifo.sv
// rtl/bpu_upd_fifo.sv - synchronous FIFO of predictor update commands
//
// Purpose : decouples branch resolution from the predictor's one-update-per-
//           cycle port.
// Ports   : clk, reset (sync, active-high)
//           push, din   - write side; push is ignored when full
//           pop, dout   - read side; dout is the head, pop ignored when empty
//           full, empty - occupancy flags

module bpu_upd_fifo
  import bpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  upd_cmd_t din,
  input  logic     pop,
  output upd_cmd_t dout,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Extra pointer MSB distinguishes full from empty; pointers wrap naturally.
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  upd_cmd_t       mem_q [DEPTH];
  upd_cmd_t       mem_d [DEPTH];
  logic           push_ok;
  logic           pop_ok;

  assign empty = wr_ptr_q == rd_ptr_q;
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push_ok) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = din;
      wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/bpu_update_ctrl.sv
// rtl/bpu_update_ctrl.sv - branch resolution to BTB/RAS update and IF redirect
//
// Purpose : classifies resolved branches into predictor maintenance commands,
//           queues them for the predictor, issues IF redirects and keeps
//           performance counters.
// Ports   : clk, reset (sync, active-high)
//           res_*        - resolved record from execute with fetch metadata
//           redirect_*   - registered one-cycle IF redirect
//           upd_stall    - predictor back-pressure
//           operate_*, pop_ras, push_ras, add_entry, delete_entry,
//           pre_error, pre_right, target_error, right_orien, right_target
//                        - update command at the FIFO head
//           perf_br_cnt, perf_mis_cnt - branches resolved / redirects issued

module bpu_update_ctrl
  import bpu_pkg::upd_cmd_t;
  import bpu_pkg::classify;
  import bpu_pkg::cmd_has_work;
  import bpu_pkg::needs_redirect;
#(
  // Must match the index width of upd_cmd_t.
  parameter int BTB_IDX_W = bpu_pkg::BTB_IDX_W,
  parameter int UPD_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [31:0]          res_pc,
  input  logic                 res_is_branch,
  input  logic                 res_is_call,
  input  logic                 res_is_ret,
  input  logic                 res_pred_hit,
  input  logic [BTB_IDX_W-1:0] res_pred_index,
  input  logic                 res_pred_taken,
  input  logic [31:0]          res_pred_target,
  input  logic                 res_act_taken,
  input  logic [31:0]          res_act_target,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  input  logic                 upd_stall,
  output logic                 operate_en,
  output logic [31:0]          operate_pc,
  output logic [BTB_IDX_W-1:0] operate_index,
  output logic                 pop_ras,
  output logic                 push_ras,
  output logic                 add_entry,
  output logic                 delete_entry,
  output logic                 pre_error,
  output logic                 pre_right,
  output logic                 target_error,
  output logic                 right_orien,
  output logic [31:0]          right_target,
  output logic [31:0]          perf_br_cnt,
  output logic [31:0]          perf_mis_cnt
);

  upd_cmd_t    res_cmd;
  upd_cmd_t    head_cmd;
  upd_cmd_t    out_cmd;
  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        fifo_push;
  logic        redir_now;

  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q,    redirect_pc_d;
  logic [31:0] perf_br_cnt_q,    perf_br_cnt_d;
  logic [31:0] perf_mis_cnt_q,   perf_mis_cnt_d;

  // No pass-through when full, even if the head pops this same cycle.
  assign res_ready = !fifo_full;
  assign accept    = res_valid && res_ready;

  assign res_cmd = classify(res_pc, res_is_branch, res_is_call, res_is_ret,
                            res_pred_hit, res_pred_index, res_pred_taken,
                            res_pred_target, res_act_taken, res_act_target);

  assign redir_now = accept && needs_redirect(res_cmd, res_pred_taken, res_act_taken);
  assign fifo_push = accept && cmd_has_work(res_cmd);

  bpu_upd_fifo #(
    .DEPTH (UPD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (res_cmd),
    .pop   (operate_en),
    .dout  (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    redirect_valid_d = redir_now;
    redirect_pc_d    = redirect_pc_q;
    perf_br_cnt_d    = perf_br_cnt_q;
    perf_mis_cnt_d   = perf_mis_cnt_q;
    if (redir_now) begin
      redirect_pc_d  = res_act_taken ? res_act_target : res_pc + 32'd4;
      perf_mis_cnt_d = perf_mis_cnt_q + 32'd1;
    end
    if (accept && res_is_branch) begin
      perf_br_cnt_d = perf_br_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      perf_br_cnt_q    <= '0;
      perf_mis_cnt_q   <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      perf_br_cnt_q    <= perf_br_cnt_d;
      perf_mis_cnt_q   <= perf_mis_cnt_d;
    end
  end

  // Head fields are forced to zero while the queue is empty so stale storage
  // never leaks onto the command bus.
  assign out_cmd    = fifo_empty ? '0 : head_cmd;
  assign operate_en = !fifo_empty && !upd_stall;

  assign operate_pc    = out_cmd.pc;
  assign operate_index = out_cmd.index;
  assign pop_ras       = out_cmd.pop_ras;
  assign push_ras      = out_cmd.push_ras;
  assign add_entry     = out_cmd.add_entry;
  assign delete_entry  = out_cmd.delete_entry;
  assign pre_error     = out_cmd.pre_error;
  assign pre_right     = out_cmd.pre_right;
  assign target_error  = out_cmd.target_error;
  assign right_orien   = out_cmd.right_orien;
  assign right_target  = out_cmd.right_target;

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign perf_br_cnt    = perf_br_cnt_q;
  assign perf_mis_cnt   = perf_mis_cnt_q;

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// tb/tb_bpu_update_ctrl.sv - directed vector bench for bpu_update_ctrl

module tb_bpu_update_ctrl;

  logic        clk;
  logic        reset;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_pc;
  logic        res_is_branch;
  logic        res_is_call;
  logic        res_is_ret;
  logic        res_pred_hit;
  logic [4:0]  res_pred_index;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        res_act_taken;
  logic [31:0] res_act_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_stall;
  logic        operate_en;
  logic [31:0] operate_pc;
  logic [4:0]  operate_index;
  logic        pop_ras, push_ras, add_entry, delete_entry;
  logic        pre_error, pre_right, target_error;
  logic        right_orien;
  logic [31:0] right_target;
  logic [31:0] perf_br_cnt;
  logic [31:0] perf_mis_cnt;

  bpu_update_ctrl #(.BTB_IDX_W(5), .UPD_DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_pc          (res_pc),
    .res_is_branch   (res_is_branch),
    .res_is_call     (res_is_call),
    .res_is_ret      (res_is_ret),
    .res_pred_hit    (res_pred_hit),
    .res_pred_index  (res_pred_index),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .res_act_taken   (res_act_taken),
    .res_act_target  (res_act_target),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .upd_stall       (upd_stall),
    .operate_en      (operate_en),
    .operate_pc      (operate_pc),
    .operate_index   (operate_index),
    .pop_ras         (pop_ras),
    .push_ras        (push_ras),
    .add_entry       (add_entry),
    .delete_entry    (delete_entry),
    .pre_error       (pre_error),
    .pre_right       (pre_right),
    .target_error    (target_error),
    .right_orien     (right_orien),
    .right_target    (right_target),
    .perf_br_cnt     (perf_br_cnt),
    .perf_mis_cnt    (perf_mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags order: {pop_ras, push_ras, add_entry, delete_entry, pre_error, pre_right, target_error}
  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        br, call, ret, hit;
    logic [4:0]  idx;
    logic        pt;
    logic [31:0] ptgt;
    logic        at;
    logic [31:0] atgt;
    logic        exp_en;
    logic [6:0]  exp_flags;
    logic        exp_redir;
    logic [31:0] exp_rpc;
  } vec_t;

  vec_t        vecs [8];
  int          errors;
  int          checks;
  logic [31:0] exp_br;
  logic [31:0] exp_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] flags_now();
    return {pop_ras, push_ras, add_entry, delete_entry, pre_error, pre_right, target_error};
  endfunction

  task automatic set_rec(input logic [31:0] pc, input logic br, input logic call, input logic ret,
                         input logic hit, input logic [4:0] idx, input logic pt,
                         input logic [31:0] ptgt, input logic at, input logic [31:0] atgt);
    res_pc = pc; res_is_branch = br; res_is_call = call; res_is_ret = ret;
    res_pred_hit = hit; res_pred_index = idx; res_pred_taken = pt;
    res_pred_target = ptgt; res_act_taken = at; res_act_target = atgt;
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".perf_br_cnt"}, perf_br_cnt, exp_br);
    check({tag, ".perf_mis_cnt"}, perf_mis_cnt, exp_mis);
  endtask

  initial begin
    errors = 0; checks = 0; exp_br = 0; exp_mis = 0;
    reset = 1'b1; res_valid = 1'b0; upd_stall = 1'b0;
    set_rec(32'h0, 0, 0, 0, 0, 5'd0, 0, 32'h0, 0, 32'h0);

    vecs[0] = '{"hit_correct", 32'h1C000000, 1,0,0,1, 5'd7,  1, 32'h1C000100, 1, 32'h1C000100,
                1, 7'b0000010, 0, 32'h0};
    vecs[1] = '{"dir_mispred", 32'h1C000040, 1,0,0,1, 5'd2,  1, 32'h1C000200, 0, 32'h0,
                1, 7'b0000100, 1, 32'h1C000044};
    vecs[2] = '{"miss_call",   32'h1C001000, 1,1,0,0, 5'd0,  0, 32'h0,        1, 32'h1C002000,
                1, 7'b0110000, 1, 32'h1C002000};
    vecs[3] = '{"alias",       32'h1C000080, 0,0,0,1, 5'd9,  1, 32'h1C000500, 0, 32'h0,
                1, 7'b0001000, 1, 32'h1C000084};
    vecs[4] = '{"tgt_err_ret", 32'h1C000100, 1,0,1,1, 5'd3,  1, 32'h1C000300, 1, 32'h1C000340,
                1, 7'b1000001, 1, 32'h1C000340};
    vecs[5] = '{"dropped",     32'h1C000200, 1,0,0,0, 5'd0,  0, 32'h0,        0, 32'h0,
                0, 7'b0000000, 0, 32'h0};
    vecs[6] = '{"pc_wrap",     32'hFFFFFFFC, 1,0,0,1, 5'd31, 1, 32'h00000010, 0, 32'h0,
                1, 7'b0000100, 1, 32'h00000000};
    vecs[7] = '{"ret_correct", 32'h1C000300, 1,0,1,1, 5'd4,  1, 32'h1C000600, 1, 32'h1C000600,
                1, 7'b1000010, 0, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst.res_ready", {31'b0, res_ready}, 32'd1);
    check("rst.operate_en", {31'b0, operate_en}, 32'd0);
    check("rst.redirect_valid", {31'b0, redirect_valid}, 32'd0);
    check("rst.redirect_pc", redirect_pc, 32'h0);
    check("rst.flags", {25'b0, flags_now()}, 32'd0);
    check_counters("rst");

    // Single-record vectors: accept, observe, then confirm pop and pulse end
    for (int i = 0; i < 8; i++) begin
      set_rec(vecs[i].pc, vecs[i].br, vecs[i].call, vecs[i].ret, vecs[i].hit, vecs[i].idx,
              vecs[i].pt, vecs[i].ptgt, vecs[i].at, vecs[i].atgt);
      res_valid = 1'b1;
      #1;
      check({vecs[i].name, ".res_ready"}, {31'b0, res_ready}, 32'd1);
      @(negedge clk);
      res_valid = 1'b0;
      if (vecs[i].br) exp_br = exp_br + 1;
      if (vecs[i].exp_redir) exp_mis = exp_mis + 1;
      check({vecs[i].name, ".operate_en"}, {31'b0, operate_en}, {31'b0, vecs[i].exp_en});
      check({vecs[i].name, ".flags"}, {25'b0, flags_now()}, {25'b0, vecs[i].exp_flags});
      check({vecs[i].name, ".redirect_valid"}, {31'b0, redirect_valid}, {31'b0, vecs[i].exp_redir});
      if (vecs[i].exp_redir) check({vecs[i].name, ".redirect_pc"}, redirect_pc, vecs[i].exp_rpc);
      if (vecs[i].exp_en) begin
        check({vecs[i].name, ".operate_pc"}, operate_pc, vecs[i].pc);
        check({vecs[i].name, ".operate_index"}, {27'b0, operate_index}, {27'b0, vecs[i].idx});
        check({vecs[i].name, ".right_orien"}, {31'b0, right_orien}, {31'b0, vecs[i].at});
        check({vecs[i].name, ".right_target"}, right_target, vecs[i].atgt);
      end
      check_counters(vecs[i].name);
      @(negedge clk);
      check({vecs[i].name, ".pulse_end"}, {31'b0, redirect_valid}, 32'd0);
      check({vecs[i].name, ".drained"}, {31'b0, operate_en}, 32'd0);
    end

    // Back-pressure: 5 back-to-back hit-correct branches with the predictor stalled
    upd_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_rec(32'h1C004000 + 32'(k * 4), 1, 0, 0, 1, 5'(10 + k), 1, 32'h1C005000, 1, 32'h1C005000);
      res_valid = 1'b1;
      #1;
      check($sformatf("bp.res_ready%0d", k), {31'b0, res_ready}, (k < 4) ? 32'd1 : 32'd0);
      if (k < 4) exp_br = exp_br + 1;
      @(negedge clk);
    end
    res_valid = 1'b0;
    check("bp.stalled_en", {31'b0, operate_en}, 32'd0);
    check_counters("bp");
    upd_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("bp.pop_en%0d", k), {31'b0, operate_en}, 32'd1);
      check($sformatf("bp.pop_idx%0d", k), {27'b0, operate_index}, 32'(10 + k));
      check($sformatf("bp.pop_pre_right%0d", k), {31'b0, pre_right}, 32'd1);
      // Full queue refuses input even in the cycle it pops
      if (k == 0) check("bp.no_passthru", {31'b0, res_ready}, 32'd0);
      @(negedge clk);
    end
    check("bp.empty_en", {31'b0, operate_en}, 32'd0);
    check("bp.ready_again", {31'b0, res_ready}, 32'd1);

    // Reset with queued commands and a mispredict arriving in the reset cycle
    upd_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_rec(32'h1C006000 + 32'(k * 4), 1, 0, 0, 1, 5'(k + 1), 1, 32'h1C007000, 1, 32'h1C007000);
      res_valid = 1'b1;
      @(negedge clk);
    end
    set_rec(32'h1C008000, 1, 0, 0, 1, 5'd5, 1, 32'h1C009000, 0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    res_valid = 1'b0;
    exp_br = 0; exp_mis = 0;
    check("mrst.operate_en", {31'b0, operate_en}, 32'd0);
    check("mrst.redirect_valid", {31'b0, redirect_valid}, 32'd0);
    check("mrst.res_ready", {31'b0, res_ready}, 32'd1);
    check_counters("mrst");
    upd_stall = 1'b0;
    @(negedge clk);
    check("mrst.fifo_empty", {31'b0, operate_en}, 32'd0);
    check("mrst.flags", {25'b0, flags_now()}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
